// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider with per-channel enable, shadowed
// divisor reload at wrap, and a global phase-align strobe.
module prog_clock_divider #(
    parameter int CHANNELS    = 2,
    parameter int WIDTH       = 26,
    parameter int DEFAULT_DIV = 25000,
    localparam int SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [CHANNELS-1:0]       enable,
    input  logic                      sync,
    input  logic                      load,
    input  logic [SEL_W-1:0]          load_channel,
    input  logic [WIDTH-1:0]          load_value,
    output logic [CHANNELS-1:0]       divided_clock,
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS*WIDTH-1:0] clock_count,
    output logic [CHANNELS-1:0]       pending
);

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0]    cnt_q    [CHANNELS];
    logic [WIDTH-1:0]    cnt_d    [CHANNELS];
    logic [WIDTH-1:0]    div_q    [CHANNELS];
    logic [WIDTH-1:0]    div_d    [CHANNELS];
    logic [WIDTH-1:0]    shadow_q [CHANNELS];
    logic [WIDTH-1:0]    shadow_d [CHANNELS];
    logic [CHANNELS-1:0] pend_q, pend_d;
    logic [CHANNELS-1:0] dclk_q, dclk_d;
    logic [CHANNELS-1:0] tick_q, tick_d;

    always_comb begin
        cnt_d    = cnt_q;
        div_d    = div_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        dclk_d   = dclk_q;
        tick_d   = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            // Out-of-range channel numbers never match any index, so they are ignored.
            if (sync) begin
                cnt_d[i]  = '0;
                dclk_d[i] = 1'b0;
                if (pend_q[i]) begin
                    div_d[i]  = shadow_q[i];
                    pend_d[i] = 1'b0;
                end
                if (load && (load_channel == SEL_W'(i))) begin
                    div_d[i]  = load_value;
                    pend_d[i] = 1'b0;
                end
            end else if (load && (load_channel == SEL_W'(i)) && !enable[i]) begin
                div_d[i]  = load_value;
                cnt_d[i]  = '0;
                pend_d[i] = 1'b0;
            end else begin
                // A wrap consumes the shadow as it was before this cycle's load.
                if (enable[i]) begin
                    if (cnt_q[i] == div_q[i]) begin
                        cnt_d[i]  = '0;
                        dclk_d[i] = ~dclk_q[i];
                        tick_d[i] = 1'b1;
                        if (pend_q[i]) begin
                            div_d[i]  = shadow_q[i];
                            pend_d[i] = 1'b0;
                        end
                    end else begin
                        cnt_d[i] = cnt_q[i] + WIDTH'(1);
                    end
                end
                if (load && (load_channel == SEL_W'(i))) begin
                    shadow_d[i] = load_value;
                    pend_d[i]   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                cnt_q[i]    <= '0;
                div_q[i]    <= DIV_RST;
                shadow_q[i] <= DIV_RST;
            end
            pend_q <= '0;
            dclk_q <= '0;
            tick_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            dclk_q   <= dclk_d;
            tick_q   <= tick_d;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_count
        assign clock_count[g*WIDTH +: WIDTH] = cnt_q[g];
    end

    assign divided_clock = dclk_q;
    assign tick          = tick_q;
    assign pending       = pend_q;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Scoreboard bench: stimulus queues hand-computed expectations tagged with a
// cycle number; a negedge monitor pops and compares them against the DUTs.
module tb_prog_clock_divider;

    localparam int F_TICK   = 0;
    localparam int F_DCLK   = 1;
    localparam int F_COUNT  = 2;
    localparam int F_PEND   = 3;
    localparam int F_TICK3  = 4;
    localparam int F_COUNT3 = 5;
    localparam int F_PEND3  = 6;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [1:0]  enable;
    logic        sync;
    logic        load;
    logic [0:0]  load_channel;
    logic [7:0]  load_value;
    logic [1:0]  divided_clock;
    logic [1:0]  tick;
    logic [15:0] clock_count;
    logic [1:0]  pending;

    logic [2:0]  enable3;
    logic        sync3;
    logic        load3;
    logic [1:0]  load_channel3;
    logic [7:0]  load_value3;
    logic [2:0]  divided_clock3;
    logic [2:0]  tick3;
    logic [23:0] clock_count3;
    logic [2:0]  pending3;

    prog_clock_divider #(.CHANNELS(2), .WIDTH(8), .DEFAULT_DIV(3)) u_dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .sync(sync),
        .load(load), .load_channel(load_channel), .load_value(load_value),
        .divided_clock(divided_clock), .tick(tick),
        .clock_count(clock_count), .pending(pending)
    );

    prog_clock_divider #(.CHANNELS(3), .WIDTH(8), .DEFAULT_DIV(3)) u_dut3 (
        .clock(clock), .reset_n(reset_n), .enable(enable3), .sync(sync3),
        .load(load3), .load_channel(load_channel3), .load_value(load_value3),
        .divided_clock(divided_clock3), .tick(tick3),
        .clock_count(clock_count3), .pending(pending3)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          cyc;
        int          field;
        int          ch;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t  sb[$];
    int    cyc = 0;
    int    compared = 0;
    int    mismatched = 0;
    string phase = "reset";

    always @(posedge clock) cyc <= cyc + 1;

    function automatic string fname(input int f);
        case (f)
            F_TICK:   return "tick";
            F_DCLK:   return "divided_clock";
            F_COUNT:  return "clock_count";
            F_PEND:   return "pending";
            F_TICK3:  return "tick(3ch)";
            F_COUNT3: return "clock_count(3ch)";
            default:  return "pending(3ch)";
        endcase
    endfunction

    function automatic logic [31:0] sample(input int f, input int ch);
        case (f)
            F_TICK:   return {31'b0, tick[ch]};
            F_DCLK:   return {31'b0, divided_clock[ch]};
            F_COUNT:  return {24'b0, clock_count[ch*8 +: 8]};
            F_PEND:   return {31'b0, pending[ch]};
            F_TICK3:  return {31'b0, tick3[ch]};
            F_COUNT3: return {24'b0, clock_count3[ch*8 +: 8]};
            default:  return {31'b0, pending3[ch]};
        endcase
    endfunction

    always @(negedge clock) begin
        for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                logic [31:0] act;
                act = sample(sb[i].field, sb[i].ch);
                compared++;
                if (act !== sb[i].val) begin
                    mismatched++;
                    $display("FAIL %s %s[%0d] cyc %0d: got %0d, expected %0d",
                             sb[i].name, fname(sb[i].field), sb[i].ch, cyc, act, sb[i].val);
                end
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                compared++;
                mismatched++;
                $display("FAIL %s %s[%0d]: stale expectation for cyc %0d, got none, expected %0d",
                         sb[i].name, fname(sb[i].field), sb[i].ch, sb[i].cyc, sb[i].val);
                sb.delete(i);
            end
        end
    end

    task automatic want(input int k, input int field, input int ch, input int val);
        exp_t e;
        e.cyc   = cyc + k;
        e.field = field;
        e.ch    = ch;
        e.val   = val;
        e.name  = phase;
        sb.push_back(e);
    endtask

    task automatic go(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        reset_n = 1'b0; enable = '0; sync = 1'b0; load = 1'b0;
        load_channel = '0; load_value = '0;
        enable3 = '0; sync3 = 1'b0; load3 = 1'b0; load_channel3 = '0; load_value3 = '0;

        go(1);
        want(1, F_COUNT, 0, 0); want(1, F_COUNT, 1, 0);
        want(1, F_TICK, 0, 0);  want(1, F_DCLK, 0, 0); want(1, F_PEND, 0, 0);
        go(1);

        phase = "free_run";
        reset_n = 1'b1; enable = 2'b11;
        want(1, F_COUNT, 0, 1); want(2, F_COUNT, 0, 2);
        want(3, F_COUNT, 0, 3); want(4, F_COUNT, 0, 0);
        want(3, F_TICK, 0, 0);  want(4, F_TICK, 0, 1);
        want(5, F_TICK, 0, 0);  want(8, F_TICK, 0, 1);
        want(3, F_DCLK, 0, 0);  want(4, F_DCLK, 0, 1);
        want(7, F_DCLK, 0, 1);  want(8, F_DCLK, 0, 0);
        want(4, F_TICK, 1, 1);  want(4, F_COUNT, 1, 0);
        go(8);

        phase = "shadow_load";
        go(1);
        load = 1'b1; load_channel = 1'b1; load_value = 8'd5;
        want(1, F_PEND, 1, 1);  want(2, F_PEND, 1, 1); want(3, F_PEND, 1, 0);
        want(3, F_TICK, 1, 1);  want(7, F_COUNT, 1, 4); want(8, F_COUNT, 1, 5);
        want(8, F_TICK, 1, 0);  want(9, F_TICK, 1, 1);  want(9, F_COUNT, 1, 0);
        want(7, F_TICK, 0, 1);
        go(1);
        load = 1'b0;
        go(10);

        phase = "sync_load";
        sync = 1'b1; load = 1'b1; load_channel = 1'b1; load_value = 8'd3;
        want(1, F_COUNT, 0, 0); want(1, F_COUNT, 1, 0);
        want(1, F_DCLK, 0, 0);  want(1, F_DCLK, 1, 0); want(1, F_PEND, 1, 0);
        want(4, F_TICK, 0, 0);  want(4, F_COUNT, 1, 3);
        want(5, F_TICK, 0, 1);  want(5, F_TICK, 1, 1);
        want(5, F_DCLK, 0, 1);  want(5, F_DCLK, 1, 1);
        want(9, F_TICK, 0, 1);  want(9, F_TICK, 1, 1);
        want(9, F_DCLK, 0, 0);  want(9, F_DCLK, 1, 0);
        go(1);
        sync = 1'b0; load = 1'b0;
        go(8);

        phase = "disable_hold";
        go(2);
        enable = 2'b10;
        want(1, F_COUNT, 0, 2);  want(1, F_TICK, 0, 0); want(5, F_COUNT, 0, 2);
        want(10, F_COUNT, 0, 2); want(10, F_DCLK, 0, 0); want(10, F_TICK, 0, 0);
        go(10);
        enable = 2'b11;
        want(1, F_COUNT, 0, 3); want(1, F_TICK, 0, 0);
        want(2, F_TICK, 0, 1);  want(2, F_COUNT, 0, 0); want(2, F_DCLK, 0, 1);
        go(2);

        phase = "div_zero";
        enable = 2'b10; load = 1'b1; load_channel = 1'b0; load_value = 8'd0;
        want(1, F_COUNT, 0, 0); want(1, F_TICK, 0, 0);
        want(1, F_DCLK, 0, 1);  want(1, F_PEND, 0, 0);
        go(1);
        load = 1'b0; enable = 2'b11;
        want(1, F_TICK, 0, 1); want(1, F_DCLK, 0, 0);
        want(2, F_TICK, 0, 1); want(2, F_DCLK, 0, 1);
        want(3, F_TICK, 0, 1); want(3, F_DCLK, 0, 0); want(3, F_COUNT, 0, 0);
        go(3);

        phase = "invalid_ch";
        load3 = 1'b1; load_channel3 = 2'd3; load_value3 = 8'd7;
        want(1, F_PEND3, 0, 0); want(1, F_PEND3, 1, 0); want(1, F_PEND3, 2, 0);
        go(1);
        load3 = 1'b0; enable3 = 3'b111;
        want(3, F_COUNT3, 0, 3); want(3, F_TICK3, 0, 0);
        want(4, F_TICK3, 0, 1);  want(4, F_TICK3, 1, 1); want(4, F_TICK3, 2, 1);
        want(4, F_COUNT3, 0, 0);
        go(4);

        phase = "overwrite_at_wrap";
        load3 = 1'b1; load_channel3 = 2'd0; load_value3 = 8'd9;
        want(1, F_PEND3, 0, 1);
        go(1);
        load_value3 = 8'd6;
        go(1);
        load3 = 1'b0;
        go(1);
        load3 = 1'b1; load_value3 = 8'd10;
        want(1, F_TICK3, 0, 1);   want(1, F_PEND3, 0, 1);
        want(7, F_COUNT3, 0, 6);  want(7, F_TICK3, 0, 0);
        want(8, F_TICK3, 0, 1);   want(8, F_PEND3, 0, 0);
        want(18, F_COUNT3, 0, 10); want(19, F_TICK3, 0, 1);
        go(1);
        load3 = 1'b0;
        go(19);

        phase = "async_reset";
        load = 1'b1; load_channel = 1'b0; load_value = 8'd5;
        go(1);
        load = 1'b0;
        go(2);
        load = 1'b1; load_value = 8'd7;
        want(1, F_PEND, 0, 1); want(1, F_COUNT, 0, 2);
        go(1);
        load = 1'b0;
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        want(0, F_COUNT, 0, 0); want(0, F_COUNT, 1, 0);
        want(0, F_TICK, 0, 0);  want(0, F_TICK, 1, 0);
        want(0, F_DCLK, 0, 0);  want(0, F_DCLK, 1, 0);
        want(0, F_PEND, 0, 0);
        go(1);

        phase = "after_reset";
        reset_n = 1'b1;
        want(1, F_COUNT, 0, 1); want(2, F_PEND, 0, 0);
        want(3, F_TICK, 0, 0);  want(4, F_TICK, 0, 1);
        want(4, F_COUNT, 0, 0); want(4, F_PEND, 0, 0);
        go(5);

        for (int n = 0; n < 20 && sb.size() != 0; n++) go(1);
        while (sb.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL %s %s[%0d]: never compared, expected %0d at cyc %0d",
                     sb[0].name, fname(sb[0].field), sb[0].ch, sb[0].val, sb[0].cyc);
            void'(sb.pop_front());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
